dut_loopback_fifo: RTL

Parametrised, clocked successor to the combinational port-loopback DUT used by the write/read port API tests. It provides NUM_CH independent loopback channels, each with a valid/ready write side, a DEPTH-entry FIFO and a valid/ready read side. A per-write transform mode lets tests check data integrity, back-pressure, occupancy and sticky status through the SST port API rather than just wire passthrough.

---
 rtl/dut_loopback_fifo_if.sv | 28 ++
 rtl/dut_loopback_fifo.sv | 81 ++++++++
 2 files changed

// File: rtl/dut_loopback_fifo_if.sv
// Handshake and status bundle for the multi-channel loopback FIFO.
// The master side is the traffic generator; the slave side is the FIFO block.
interface dut_loopback_fifo_if #(
  parameter int WIDTH  = 128,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_CH-1:0]       wr_valid;
  logic [NUM_CH-1:0]       wr_ready;
  logic [NUM_CH*WIDTH-1:0] wr_data;
  logic [NUM_CH-1:0]       rd_valid;
  logic [NUM_CH-1:0]       rd_ready;
  logic [NUM_CH*WIDTH-1:0] rd_data;
  logic [NUM_CH*CNT_W-1:0] level;
  logic [NUM_CH-1:0]       overflow;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, level, overflow
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, level, overflow
  );
endinterface

// File: rtl/dut_loopback_fifo.sv
// NUM_CH independent loopback FIFOs; each push stores a transformed copy of the
// write data, each channel reports its occupancy and a sticky overflow flag.
module dut_loopback_fifo #(
  parameter int WIDTH  = 128,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [1:0]            mode,
  dut_loopback_fifo_if.slave    bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  function automatic logic [WIDTH-1:0] xform(input logic [1:0] m, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = d;
    case (m)
      2'd1: r = ~d;
      2'd2: for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
      2'd3: r = d + WIDTH'(1);
      default: r = d;
    endcase
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [WIDTH-1:0] mem [DEPTH];
      logic [PTR_W-1:0] wr_ptr_reg;
      logic [PTR_W-1:0] rd_ptr_reg;
      logic [CNT_W-1:0] level_reg;
      logic             overflow_reg;
      logic             full;
      logic             empty;
      logic             push;
      logic             pop;

      // Full/empty come only from level; pointers are free-running modulo DEPTH.
      assign full  = (level_reg == CNT_W'(DEPTH));
      assign empty = (level_reg == '0);
      assign push  = bus.wr_valid[gi] & ~full;
      assign pop   = bus.rd_ready[gi] & ~empty;

      always_ff @(posedge clk) begin
        if (push && !clear) begin
          mem[wr_ptr_reg] <= xform(mode, bus.wr_data[gi*WIDTH +: WIDTH]);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_reg   <= '0;
          rd_ptr_reg   <= '0;
          level_reg    <= '0;
          overflow_reg <= 1'b0;
        end else if (clear) begin
          wr_ptr_reg   <= '0;
          rd_ptr_reg   <= '0;
          level_reg    <= '0;
          overflow_reg <= 1'b0;
        end else begin
          if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          if (push && !pop)      level_reg <= level_reg + CNT_W'(1);
          else if (pop && !push) level_reg <= level_reg - CNT_W'(1);
          if (bus.wr_valid[gi] && full) overflow_reg <= 1'b1;
        end
      end

      assign bus.wr_ready[gi]                = ~full;
      assign bus.rd_valid[gi]                = ~empty;
      assign bus.rd_data[gi*WIDTH +: WIDTH]  = empty ? '0 : mem[rd_ptr_reg];
      assign bus.level[gi*CNT_W +: CNT_W]    = level_reg;
      assign bus.overflow[gi]                = overflow_reg;
    end
  endgenerate
endmodule
